// File: rtl/wb_write_queue_if.sv
`default_nettype none
// ============================================================================
// Module   : wb_write_queue_if
// Brief    : Bus bundle between MEM/WB, the writeback queue, the register
//            file write port and the ID-stage forwarding lookup.
// Revision : 1.0 - initial release
// ============================================================================
interface wb_write_queue_if #(
  parameter int DEPTH = 4,
  parameter int AW    = 4,
  parameter int DW    = 16
);
  localparam int CW = $clog2(DEPTH) + 1;

  // writeback result offer
  logic          in_valid;
  logic          in_ready;
  logic [AW-1:0] in_reg1;
  logic [DW-1:0] in_data1;
  logic          in_dual;
  logic [AW-1:0] in_reg2;
  logic [DW-1:0] in_data2;

  // register file write side
  logic          drain_en;
  logic [AW-1:0] WriteReg1;
  logic [DW-1:0] WriteData1;
  logic [AW-1:0] WriteReg2;
  logic [DW-1:0] WriteData2;
  logic          RegWrite;
  logic          WriteOP2;

  // forwarding lookup
  logic [AW-1:0] q_reg1;
  logic [AW-1:0] q_reg2;
  logic          q_hit1;
  logic          q_hit2;
  logic [DW-1:0] q_data1;
  logic [DW-1:0] q_data2;

  // status
  logic [CW-1:0] count;
  logic          empty;

  modport master (
    output in_valid, in_reg1, in_data1, in_dual, in_reg2, in_data2,
           drain_en, q_reg1, q_reg2,
    input  in_ready, WriteReg1, WriteData1, WriteReg2, WriteData2,
           RegWrite, WriteOP2, q_hit1, q_hit2, q_data1, q_data2, count, empty
  );

  modport slave (
    input  in_valid, in_reg1, in_data1, in_dual, in_reg2, in_data2,
           drain_en, q_reg1, q_reg2,
    output in_ready, WriteReg1, WriteData1, WriteReg2, WriteData2,
           RegWrite, WriteOP2, q_hit1, q_hit2, q_data1, q_data2, count, empty
  );
endinterface
`default_nettype wire

// File: rtl/wb_write_queue.sv
`default_nettype none
// ============================================================================
// Module   : wb_write_queue
// Brief    : DEPTH-entry writeback queue feeding a dual-write-port register
//            file one entry per cycle, with a two-port youngest-wins lookup
//            over pending writes for ID-stage forwarding.
// Revision : 1.0 - initial release
// ============================================================================
module wb_write_queue #(
  parameter int DEPTH = 4,
  parameter int AW    = 4,
  parameter int DW    = 16
) (
  input  wire logic         clk,
  input  wire logic         rst,
  wb_write_queue_if.slave   bus
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  // queue storage
  logic [AW-1:0] ent_reg1_q  [DEPTH];
  logic [DW-1:0] ent_data1_q [DEPTH];
  logic          ent_dual_q  [DEPTH];
  logic [AW-1:0] ent_reg2_q  [DEPTH];
  logic [DW-1:0] ent_data2_q [DEPTH];

  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q,  count_d;

  // register file output stage
  logic [AW-1:0] wreg1_q,  wreg1_d;
  logic [DW-1:0] wdata1_q, wdata1_d;
  logic [AW-1:0] wreg2_q,  wreg2_d;
  logic [DW-1:0] wdata2_q, wdata2_d;
  logic          regwr_q,  regwr_d;
  logic          op2_q,    op2_d;

  logic          w_ready;
  logic          w_push;
  logic          w_pop;
  logic          w_same_dest;

  assign w_ready     = (count_q < CW'(DEPTH));
  assign w_push      = bus.in_valid & w_ready;
  assign w_pop       = bus.drain_en & (count_q != '0);
  assign w_same_dest = bus.in_dual & (bus.in_reg1 == bus.in_reg2);

  // Next-state: pointers, occupancy and the output stage loading the head entry
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    wreg1_d  = wreg1_q;
    wdata1_d = wdata1_q;
    wreg2_d  = wreg2_q;
    wdata2_d = wdata2_q;
    regwr_d  = 1'b0;
    op2_d    = 1'b0;
    if (w_pop) begin
      wreg1_d  = ent_reg1_q[rd_ptr_q];
      wdata1_d = ent_data1_q[rd_ptr_q];
      wreg2_d  = ent_reg2_q[rd_ptr_q];
      wdata2_d = ent_data2_q[rd_ptr_q];
      regwr_d  = 1'b1;
      op2_d    = ent_dual_q[rd_ptr_q];
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    if (w_push) begin
      wr_ptr_d = wr_ptr_q + 1'b1;
    end
    case ({w_push, w_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // Control state register; reset discards all queued entries
  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      wreg1_q  <= '0;
      wdata1_q <= '0;
      wreg2_q  <= '0;
      wdata2_q <= '0;
      regwr_q  <= 1'b0;
      op2_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      wreg1_q  <= wreg1_d;
      wdata1_q <= wdata1_d;
      wreg2_q  <= wreg2_d;
      wdata2_q <= wdata2_d;
      regwr_q  <= regwr_d;
      op2_q    <= op2_d;
    end
  end

  // Entry write; a same-destination dual collapses to a single port-2 write
  always_ff @(posedge clk) begin
    if (w_push) begin
      ent_reg1_q[wr_ptr_q]  <= w_same_dest ? bus.in_reg2  : bus.in_reg1;
      ent_data1_q[wr_ptr_q] <= w_same_dest ? bus.in_data2 : bus.in_data1;
      ent_dual_q[wr_ptr_q]  <= bus.in_dual & ~w_same_dest;
      ent_reg2_q[wr_ptr_q]  <= bus.in_reg2;
      ent_data2_q[wr_ptr_q] <= bus.in_data2;
    end
  end

  // Scan oldest to youngest so later matches override; the in-flight output
  // stage is older than anything still queued. Returns {hit, data}.
  function automatic logic [DW:0] lookup(input logic [AW-1:0] addr);
    logic [DW:0] r;
    r = '0;
    if (regwr_q) begin
      if (wreg1_q == addr)          r = {1'b1, wdata1_q};
      if (op2_q && wreg2_q == addr) r = {1'b1, wdata2_q};
    end
    for (int k = 0; k < DEPTH; k++) begin
      if (CW'(k) < count_q) begin
        if (ent_reg1_q[rd_ptr_q + PW'(k)] == addr)
          r = {1'b1, ent_data1_q[rd_ptr_q + PW'(k)]};
        if (ent_dual_q[rd_ptr_q + PW'(k)] && ent_reg2_q[rd_ptr_q + PW'(k)] == addr)
          r = {1'b1, ent_data2_q[rd_ptr_q + PW'(k)]};
      end
    end
    return r;
  endfunction

  logic [DW:0] w_look1;
  logic [DW:0] w_look2;

  // Independent forwarding searches for the two read addresses
  always_comb begin
    w_look1 = lookup(bus.q_reg1);
    w_look2 = lookup(bus.q_reg2);
  end

  assign bus.in_ready   = w_ready;
  assign bus.WriteReg1  = wreg1_q;
  assign bus.WriteData1 = wdata1_q;
  assign bus.WriteReg2  = wreg2_q;
  assign bus.WriteData2 = wdata2_q;
  assign bus.RegWrite   = regwr_q;
  assign bus.WriteOP2   = op2_q;
  assign bus.q_hit1     = w_look1[DW];
  assign bus.q_data1    = w_look1[DW-1:0];
  assign bus.q_hit2     = w_look2[DW];
  assign bus.q_data2    = w_look2[DW-1:0];
  assign bus.count      = count_q;
  assign bus.empty      = (count_q == '0);

endmodule
`default_nettype wire

// File: tb/tb_wb_write_queue.sv
`default_nettype none
// ============================================================================
// Module   : tb_wb_write_queue
// Brief    : Self-checking bench for wb_write_queue: directed scenarios plus
//            randomized traffic against a queue-based reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_wb_write_queue;
  localparam int DEPTH = 4;
  localparam int AW    = 4;
  localparam int DW    = 16;

  logic clk;
  logic rst;
  int   n_chk;
  int   n_fail;

  wb_write_queue_if #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) bus ();

  wb_write_queue #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [AW-1:0] r1;
    logic [DW-1:0] d1;
    bit            du;
    logic [AW-1:0] r2;
    logic [DW-1:0] d2;
  } ent_t;

  // reference model state
  ent_t          mq[$];
  bit            m_rw;
  bit            m_op2;
  logic [AW-1:0] m_r1, m_r2;
  logic [DW-1:0] m_d1, m_d2;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Youngest pending write wins; within an entry port 2 beats port 1;
  // the write being committed right now is the oldest candidate.
  function automatic logic [DW:0] ref_lookup(input logic [AW-1:0] a);
    for (int i = mq.size() - 1; i >= 0; i--) begin
      if (mq[i].du && mq[i].r2 == a) return {1'b1, mq[i].d2};
      if (mq[i].r1 == a)             return {1'b1, mq[i].d1};
    end
    if (m_rw) begin
      if (m_op2 && m_r2 == a) return {1'b1, m_d2};
      if (m_r1 == a)          return {1'b1, m_d1};
    end
    return '0;
  endfunction

  // One clock: drive inputs, compare every output with the model, advance model.
  task automatic cyc(input bit rstn, input bit v,
                     input logic [AW-1:0] r1, input logic [DW-1:0] d1,
                     input bit du, input logic [AW-1:0] r2, input logic [DW-1:0] d2,
                     input bit dr, input logic [AW-1:0] a1, input logic [AW-1:0] a2);
    logic [DW:0] e1, e2;
    bit   do_push, do_pop;
    ent_t e;
    rst          = rstn;
    bus.in_valid = v;
    bus.in_reg1  = r1;
    bus.in_data1 = d1;
    bus.in_dual  = du;
    bus.in_reg2  = r2;
    bus.in_data2 = d2;
    bus.drain_en = dr;
    bus.q_reg1   = a1;
    bus.q_reg2   = a2;
    #1;
    e1 = ref_lookup(a1);
    e2 = ref_lookup(a2);
    check("in_ready", 32'(bus.in_ready), 32'(mq.size() < DEPTH));
    check("count",    32'(bus.count),    32'(mq.size()));
    check("empty",    32'(bus.empty),    32'(mq.size() == 0));
    check("RegWrite", 32'(bus.RegWrite), 32'(m_rw));
    check("WriteOP2", 32'(bus.WriteOP2), 32'(m_op2));
    check("WriteReg1",  32'(bus.WriteReg1),  32'(m_r1));
    check("WriteData1", 32'(bus.WriteData1), 32'(m_d1));
    check("WriteReg2",  32'(bus.WriteReg2),  32'(m_r2));
    check("WriteData2", 32'(bus.WriteData2), 32'(m_d2));
    check("q_hit1",  32'(bus.q_hit1),  32'(e1[DW]));
    check("q_data1", 32'(bus.q_data1), 32'(e1[DW-1:0]));
    check("q_hit2",  32'(bus.q_hit2),  32'(e2[DW]));
    check("q_data2", 32'(bus.q_data2), 32'(e2[DW-1:0]));

    do_pop  = dr && (mq.size() > 0);
    do_push = v && (mq.size() < DEPTH);
    if (!rstn) begin
      mq.delete();
      m_rw = 0; m_op2 = 0; m_r1 = '0; m_r2 = '0; m_d1 = '0; m_d2 = '0;
    end else begin
      if (do_pop) begin
        e = mq.pop_front();
        m_rw = 1; m_op2 = e.du;
        m_r1 = e.r1; m_d1 = e.d1; m_r2 = e.r2; m_d2 = e.d2;
      end else begin
        m_rw = 0; m_op2 = 0;
      end
      if (do_push) begin
        if (du && r1 == r2) e = '{r1: r2, d1: d2, du: 0, r2: r2, d2: d2};
        else                e = '{r1: r1, d1: d1, du: du, r2: r2, d2: d2};
        mq.push_back(e);
      end
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle(input bit dr);
    cyc(1, 0, '0, '0, 0, '0, '0, dr, '0, '0);
  endtask

  task automatic push1(input logic [AW-1:0] r, input logic [DW-1:0] d, input bit dr);
    cyc(1, 1, r, d, 0, '0, '0, dr, '0, '0);
  endtask

  initial begin
    n_chk  = 0;
    n_fail = 0;
    m_rw = 0; m_op2 = 0; m_r1 = '0; m_r2 = '0; m_d1 = '0; m_d2 = '0;
    rst = 1'b0;
    bus.in_valid = 0; bus.in_reg1 = '0; bus.in_data1 = '0; bus.in_dual = 0;
    bus.in_reg2 = '0; bus.in_data2 = '0; bus.drain_en = 0;
    bus.q_reg1 = '0; bus.q_reg2 = '0;
    @(posedge clk);
    @(negedge clk);

    // reset state
    cyc(0, 0, '0, '0, 0, '0, '0, 0, '0, '0);
    check("rst_count", 32'(bus.count), 32'h0);
    check("rst_regwrite", 32'(bus.RegWrite), 32'h0);
    check("rst_wdata1", 32'(bus.WriteData1), 32'h0);

    // single write, no bypass
    push1(4'd3, 16'h1234, 1);
    check("single_nobypass", 32'(bus.RegWrite), 32'h0);
    idle(1);
    check("single_rw",  32'(bus.RegWrite),   32'h1);
    check("single_reg", 32'(bus.WriteReg1),  32'h3);
    check("single_dat", 32'(bus.WriteData1), 32'h1234);
    check("single_op2", 32'(bus.WriteOP2),   32'h0);
    check("single_cnt", 32'(bus.count),      32'h0);
    idle(1);
    check("single_end", 32'(bus.RegWrite), 32'h0);

    // dual write
    cyc(1, 1, 4'd4, 16'hAAAA, 1, 4'd5, 16'h5555, 1, '0, '0);
    idle(1);
    check("dual_op2",  32'(bus.WriteOP2),   32'h1);
    check("dual_reg1", 32'(bus.WriteReg1),  32'h4);
    check("dual_reg2", 32'(bus.WriteReg2),  32'h5);
    check("dual_dat2", 32'(bus.WriteData2), 32'h5555);
    idle(1);

    // fill to full, fifth offer refused, drain in order
    for (int k = 0; k < 5; k++) begin
      push1(AW'(8 + k), DW'(16'h0100 + k), 0);
      if (k == 3) check("full_count", 32'(bus.count), 32'h4);
    end
    check("full_held", 32'(bus.count), 32'h4);
    for (int k = 0; k < 4; k++) begin
      idle(1);
      check("fifo_order", 32'(bus.WriteReg1), 32'(8 + k));
    end
    idle(0);

    // forwarding: youngest wins
    push1(4'd7, 16'h0001, 0);
    push1(4'd7, 16'h0002, 0);
    cyc(1, 0, '0, '0, 0, '0, '0, 0, 4'd7, 4'd8);
    check("fwd_hit1",  32'(bus.q_hit1),  32'h1);
    check("fwd_data1", 32'(bus.q_data1), 32'h2);
    check("fwd_hit2",  32'(bus.q_hit2),  32'h0);
    idle(1); idle(1); idle(1);

    // same-destination dual collapses to one port-2 write
    cyc(1, 1, 4'd2, 16'h1111, 1, 4'd2, 16'h2222, 1, '0, '0);
    idle(1);
    check("same_dat1", 32'(bus.WriteData1), 32'h2222);
    check("same_op2",  32'(bus.WriteOP2),   32'h0);
    idle(1);

    // reset with three entries queued
    push1(4'd1, 16'h00A1, 0);
    push1(4'd2, 16'h00A2, 0);
    push1(4'd3, 16'h00A3, 0);
    cyc(0, 0, '0, '0, 0, '0, '0, 1, '0, '0);
    check("mid_rst_count", 32'(bus.count), 32'h0);
    check("mid_rst_rw",    32'(bus.RegWrite), 32'h0);
    for (int k = 0; k < 3; k++) begin
      idle(1);
      check("post_rst_rw", 32'(bus.RegWrite), 32'h0);
    end

    // randomized traffic
    for (int i = 0; i < 600; i++) begin
      bit rn, v, du, dr;
      int pdr;
      pdr = ((i / 50) % 2 == 0) ? 30 : 85;
      rn  = ($urandom_range(0, 99) != 0);
      v   = ($urandom_range(0, 99) < 60);
      du  = $urandom_range(0, 1) == 1;
      dr  = ($urandom_range(0, 99) < pdr);
      cyc(rn, v, AW'($urandom_range(0, 7)), DW'($urandom), du,
          AW'($urandom_range(0, 7)), DW'($urandom), dr,
          AW'($urandom_range(0, 8)), AW'($urandom_range(0, 8)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
`default_nettype wire
